pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for a MIPS-style core with one architectural
// branch delay slot. A taken branch/jump decision is captured while the
// current instruction executes. The next pc_advance steps into the delay
// slot. The pc_advance after that redirects to the captured target.
// A redirect to address 0 halts the sequencer.
//
// Optional feature (macro PC_ALIGN_CHECK_EN):
//   defined   - a misaligned redirect target halts the sequencer, leaves pc
//               on the delay-slot instruction and raises a sticky addr_err.
//   undefined - no addr_err port; the low two target bits are forced to 00
//               on redirect.
//
// Ports
//   clk           in   1  rising-edge clock
//   reset         in   1  synchronous active-high reset
//   pc_advance    in   1  current instruction completes this cycle
//   jump_en       in   1  branch decision valid this cycle
//   jump_in       in   1  branch/jump taken (qualified by jump_en)
//   jump_target   in  32  byte address of the branch/jump destination
//   pc            out 32  address of the instruction being fetched/executed
//   pc_link       out 32  pc + 8, link value for JAL/JALR/BLTZAL/BGEZAL
//   in_delay_slot out  1  instruction at pc is a delay-slot instruction
//   active        out  1  sequencer running; low once halted
//   addr_err      out  1  misaligned redirect seen (PC_ALIGN_CHECK_EN only)
// ---------------------------------------------------------------------------
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_advance,
    input  logic        jump_en,
    input  logic        jump_in,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] pc_link,
    output logic        in_delay_slot,
    output logic        active
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        addr_err
`endif
);

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        SEQ  = 2'd0,   // sequential execution, may hold a pending target
        SLOT = 2'd1,   // executing the delay-slot instruction
        HALT = 2'd2    // stopped until reset
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        taken_q, taken_d;
    logic        ds_q, ds_d;
    logic        active_q, active_d;
`ifdef PC_ALIGN_CHECK_EN
    logic        aerr_q, aerr_d;
`endif

    logic        take;
    logic [31:0] redirect_pc;

    assign take = jump_en & jump_in;

`ifdef PC_ALIGN_CHECK_EN
    // Misaligned targets are trapped, so the target is used as is.
    assign redirect_pc = tgt_q;
`else
    // No trap available: drop the byte-offset bits instead.
    assign redirect_pc = {tgt_q[31:2], 2'b00};
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEQ;
            pc_q     <= RESET_PC;
            tgt_q    <= 32'h0000_0000;
            taken_q  <= 1'b0;
            ds_q     <= 1'b0;
            active_q <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            aerr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            taken_q  <= taken_d;
            ds_q     <= ds_d;
            active_q <= active_d;
`ifdef PC_ALIGN_CHECK_EN
            aerr_q   <= aerr_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a hold-value default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        taken_d  = taken_q;
        ds_d     = ds_q;
        active_d = active_q;
`ifdef PC_ALIGN_CHECK_EN
        aerr_d   = aerr_q;
`endif

        unique case (state_q)
            SEQ: begin
                if (pc_advance) begin
                    pc_d = pc_q + 32'd4;   // wraps naturally at 2^32
                    if (taken_q || take) begin
                        // The next instruction is the delay slot. A decision
                        // arriving with this advance supplies the target.
                        state_d = SLOT;
                        taken_d = 1'b0;
                        ds_d    = 1'b1;
                        if (take) begin
                            tgt_d = jump_target;
                        end
                    end
                end else if (take) begin
                    // Latest decision before the advance wins.
                    taken_d = 1'b1;
                    tgt_d   = jump_target;
                end
            end

            SLOT: begin
                // Branch decisions from the delay-slot instruction are ignored.
                if (pc_advance) begin
                    if (tgt_q == 32'h0000_0000) begin
                        pc_d     = 32'h0000_0000;
                        state_d  = HALT;
                        active_d = 1'b0;
                        ds_d     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                    end else if (tgt_q[1:0] != 2'b00) begin
                        // pc stays on the delay-slot instruction for debug.
                        state_d  = HALT;
                        active_d = 1'b0;
                        aerr_d   = 1'b1;
`endif
                    end else begin
                        pc_d    = redirect_pc;
                        ds_d    = 1'b0;
                        state_d = SEQ;
                    end
                end
            end

            HALT: begin
                // Everything holds until reset.
            end

            default: begin
                state_d = SEQ;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign pc            = pc_q;
    assign pc_link       = pc_q + 32'd8;
    assign in_delay_slot = ds_q;
    assign active        = active_q;
`ifdef PC_ALIGN_CHECK_EN
    assign addr_err      = aerr_q;
`endif

endmodule
